// File: rtl/mb_tx_pkg.sv
// ============================================================================
// Module  : mb_tx_pkg
// Brief   : Shared mainband TX/RX types and default lane geometry.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

package mb_tx_pkg;

  localparam int MB_LANES     = 16;
  localparam int MB_SER_RATIO = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } mb_ser_state_e;

endpackage

`default_nettype wire

// File: rtl/mb_ser_lane.sv
// ============================================================================
// Module  : mb_ser_lane
// Brief   : One lane of the serializer: loadable shift register, LSB/MSB first.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module mb_ser_lane #(
  parameter int SER_RATIO = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic                 i_load_msb,
  input  logic [SER_RATIO-1:0] i_load_data,
  input  logic                 i_shift,
  input  logic                 i_msb,
  output logic                 o_ser
);

  logic [SER_RATIO-1:0] r_shift;
  logic                 r_ser;

  assign o_ser = r_ser;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_ser   <= 1'b0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_ser   <= 1'b0;
    end else if (i_load) begin
      // The first bit goes straight to the output flop on the load edge.
      if (i_load_msb) begin
        r_ser   <= i_load_data[SER_RATIO-1];
        r_shift <= {i_load_data[SER_RATIO-2:0], 1'b0};
      end else begin
        r_ser   <= i_load_data[0];
        r_shift <= {1'b0, i_load_data[SER_RATIO-1:1]};
      end
    end else if (i_shift) begin
      if (i_msb) begin
        r_ser   <= r_shift[SER_RATIO-1];
        r_shift <= {r_shift[SER_RATIO-2:0], 1'b0};
      end else begin
        r_ser   <= r_shift[0];
        r_shift <= {1'b0, r_shift[SER_RATIO-1:1]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mb_tx_serializer_multi.sv
// ============================================================================
// Module  : mb_tx_serializer_multi
// Brief   : Multi-lane mainband TX serializer with one-deep holding buffer.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module mb_tx_serializer_multi
  import mb_tx_pkg::*;
#(
  parameter int LANES     = MB_LANES,
  parameter int SER_RATIO = MB_SER_RATIO,
  parameter int CNT_W     = $clog2(SER_RATIO)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_ser_en,
  input  logic                       i_msb_first,
  input  logic [LANES*SER_RATIO-1:0] i_data,
  input  logic                       i_data_valid,
  output logic                       o_data_ready,
  output logic [LANES-1:0]           o_ser_data,
  output logic                       o_valid_lane,
  output logic                       o_clk_en,
  output logic                       o_word_done
);

  localparam logic [CNT_W-1:0] c_LAST_UI = CNT_W'(SER_RATIO - 1);

  mb_ser_state_e              r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [LANES*SER_RATIO-1:0] r_hold;
  logic                       r_hold_mode;
  logic                       r_hold_valid;
  logic                       r_mode;
  logic                       r_rst_done;

  logic w_shifting;
  logic w_last_ui;
  logic w_accept;
  logic w_load;
  logic w_lane_clr;
  logic w_lane_shift;

  assign w_shifting   = (r_state == ST_SHIFT);
  assign w_last_ui    = w_shifting && (r_cnt == c_LAST_UI);
  // Ready is held low for the first cycle out of reset so it reads 0 under reset.
  assign o_data_ready = i_ser_en & r_rst_done & ~r_hold_valid;
  assign w_accept     = i_data_valid & o_data_ready;
  assign w_load       = i_ser_en & r_hold_valid & (~w_shifting | w_last_ui);
  assign w_lane_clr   = ~i_ser_en | (w_last_ui & ~w_load);
  assign w_lane_shift = w_shifting & ~w_last_ui;

  assign o_valid_lane = w_shifting;
  assign o_clk_en     = w_shifting;
  assign o_word_done  = w_last_ui;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_mode  <= 1'b0;
      r_hold_valid <= 1'b0;
      r_mode       <= 1'b0;
      r_rst_done   <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (!i_ser_en) begin
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_hold_valid <= 1'b0;
      end else begin
        if (w_load) begin
          r_state <= ST_SHIFT;
          r_cnt   <= '0;
          r_mode  <= r_hold_mode;
        end else if (w_shifting) begin
          if (w_last_ui) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Accept needs an empty buffer and load needs a full one: never both.
        if (w_accept) begin
          r_hold       <= i_data;
          r_hold_mode  <= i_msb_first;
          r_hold_valid <= 1'b1;
        end else if (w_load) begin
          r_hold_valid <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      mb_ser_lane #(
        .SER_RATIO (SER_RATIO)
      ) u_lane (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_lane_clr),
        .i_load      (w_load),
        .i_load_msb  (r_hold_mode),
        .i_load_data (r_hold[l*SER_RATIO +: SER_RATIO]),
        .i_shift     (w_lane_shift),
        .i_msb       (r_mode),
        .o_ser       (o_ser_data[l])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mb_tx_serializer_multi.sv
// ============================================================================
// Module  : tb_mb_tx_serializer_multi
// Brief   : Self-checking bench for the multi-lane TX serializer.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module tb_mb_tx_serializer_multi;

  localparam int LANES     = 4;
  localparam int SER_RATIO = 8;
  localparam int W         = LANES * SER_RATIO;

  logic             i_clk        = 1'b0;
  logic             i_rst_n      = 1'b1;
  logic             i_ser_en     = 1'b0;
  logic             i_msb_first  = 1'b0;
  logic [W-1:0]     i_data       = '0;
  logic             i_data_valid = 1'b0;
  logic             o_data_ready;
  logic [LANES-1:0] o_ser_data;
  logic             o_valid_lane;
  logic             o_clk_en;
  logic             o_word_done;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int first_acc;

  logic [LANES-1:0] q_data[$];
  bit               q_done[$];
  int               q_cyc[$];
  logic [W-1:0]     w_q[$];
  bit               m_q[$];

  mb_tx_serializer_multi #(
    .LANES     (LANES),
    .SER_RATIO (SER_RATIO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ser_en     (i_ser_en),
    .i_msb_first  (i_msb_first),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_ser_data   (o_ser_data),
    .o_valid_lane (o_valid_lane),
    .o_clk_en     (o_clk_en),
    .o_word_done  (o_word_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Capture every data-carrying UI; idle UIs must be fully quiet.
  always @(negedge i_clk) begin
    n_total++;
    if (o_clk_en !== o_valid_lane) begin
      n_bad++;
      $display("FAIL clk_en_eq_valid got=%b exp=%b cyc=%0d", o_clk_en, o_valid_lane, cyc);
    end
    if (o_valid_lane === 1'b1) begin
      q_data.push_back(o_ser_data);
      q_done.push_back(o_word_done);
      q_cyc.push_back(cyc);
    end else begin
      n_total++;
      if (o_ser_data !== '0 || o_word_done !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_quiet ser=%b done=%b exp=0/0 cyc=%0d", o_ser_data, o_word_done, cyc);
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] wd;
    for (int b = 0; b < W; b++) wd[b] = 1'($urandom_range(0, 1));
    return wd;
  endfunction

  // Reference: UI t of a word carries bit t (LSB first) or bit R-1-t (MSB first).
  function automatic logic [LANES-1:0] exp_ui(input logic [W-1:0] wd, input bit msb, input int t);
    logic [LANES-1:0] v;
    for (int l = 0; l < LANES; l++)
      v[l] = msb ? wd[l*SER_RATIO + SER_RATIO-1-t] : wd[l*SER_RATIO + t];
    return v;
  endfunction

  // Time-ordered bits of one lane for captured word k; bit t = UI t.
  function automatic logic [SER_RATIO-1:0] lane_seq(input int lane, input int k);
    logic [SER_RATIO-1:0] s;
    s = '0;
    for (int t = 0; t < SER_RATIO; t++)
      if (k*SER_RATIO + t < q_data.size()) s[t] = q_data[k*SER_RATIO + t][lane];
    return s;
  endfunction

  task automatic clear_capture();
    q_data.delete(); q_done.delete(); q_cyc.delete();
  endtask

  task automatic accept_word(input logic [W-1:0] d, input bit m, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    i_data = d; i_msb_first = m; i_data_valid = 1'b1;
    for (int c = 0; c < 4*SER_RATIO && !ok; c++) begin
      @(negedge i_clk);
      if (o_data_ready === 1'b1) begin ok = 1'b1; acc = cyc + 1; end
      @(posedge i_clk); #1;
    end
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept_timeout got_ready=0 exp_ready=1");
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    logic [LANES-1:0] e;
    logic [W-1:0] rec;
    n = w_q.size() * SER_RATIO;
    n_total++;
    if (q_data.size() != n) begin
      n_bad++;
      $display("FAIL %s ui_count got=%0d exp=%0d", tag, q_data.size(), n);
    end
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      int k, t;
      k = i / SER_RATIO;
      t = i % SER_RATIO;
      e = exp_ui(w_q[k], m_q[k], t);
      n_total++;
      if (q_data[i] !== e) begin
        n_bad++;
        $display("FAIL %s ui_bits word=%0d ui=%0d got=%b exp=%b", tag, k, t, q_data[i], e);
      end
      n_total++;
      if (q_cyc[i] != first_acc + 1 + i) begin
        n_bad++;
        $display("FAIL %s ui_timing ui=%0d got_cyc=%0d exp_cyc=%0d", tag, i, q_cyc[i], first_acc + 1 + i);
      end
      n_total++;
      if (q_done[i] !== (t == SER_RATIO-1)) begin
        n_bad++;
        $display("FAIL %s word_done ui=%0d got=%b exp=%b", tag, i, q_done[i], (t == SER_RATIO-1));
      end
    end
    // Deserialize the captured stream and compare whole words.
    for (int k = 0; k < w_q.size(); k++) begin
      if ((k+1)*SER_RATIO <= q_data.size()) begin
        rec = '0;
        for (int t = 0; t < SER_RATIO; t++)
          for (int l = 0; l < LANES; l++)
            rec[l*SER_RATIO + (m_q[k] ? SER_RATIO-1-t : t)] = q_data[k*SER_RATIO + t][l];
        n_total++;
        if (rec !== w_q[k]) begin
          n_bad++;
          $display("FAIL %s loopback word=%0d got=%h exp=%h", tag, k, rec, w_q[k]);
        end
      end
    end
  endtask

  // Drive w_q/m_q with valid held high, disturb the inputs afterwards, then check.
  task automatic run_queued(input string tag);
    int acc;
    clear_capture();
    for (int k = 0; k < w_q.size(); k++) begin
      accept_word(w_q[k], m_q[k], acc);
      if (k == 0) first_acc = acc;
      if (k + 1 < w_q.size()) i_msb_first = m_q[k+1];
      else i_msb_first = ~m_q[k];
    end
    i_data_valid = 1'b0;
    i_data       = rand_word();
    repeat (w_q.size()*SER_RATIO + 4) @(posedge i_clk);
    #1;
    check_stream(tag);
  endtask

  task automatic test_reset();
    #1 i_rst_n = 1'b0;
    i_ser_en = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      n_total++;
      if ({o_data_ready, o_ser_data, o_valid_lane, o_clk_en, o_word_done} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs got=%b exp=0", {o_data_ready, o_ser_data, o_valid_lane, o_clk_en, o_word_done});
      end
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    n_total++;
    if (o_data_ready !== 1'b1 || o_valid_lane !== 1'b0 || o_ser_data !== '0) begin
      n_bad++;
      $display("FAIL ready_after_release ready=%b valid=%b ser=%b exp=1/0/0", o_data_ready, o_valid_lane, o_ser_data);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_single_lsb();
    logic [W-1:0] wd;
    wd = rand_word();
    wd[15:0] = 16'h3CA5;
    w_q = '{wd}; m_q = '{1'b0};
    run_queued("single_lsb");
    n_total++;
    if (lane_seq(0, 0) !== 8'hA5 || lane_seq(1, 0) !== 8'h3C) begin
      n_bad++;
      $display("FAIL lsb_lane_seq got=%h/%h exp=a5/3c", lane_seq(0, 0), lane_seq(1, 0));
    end
  endtask

  task automatic test_msb();
    logic [W-1:0] wd;
    wd = rand_word();
    wd[15:0] = 16'h3CA5;
    w_q = '{wd}; m_q = '{1'b1};
    run_queued("msb_a5");
    n_total++;
    if (lane_seq(0, 0) !== 8'hA5 || lane_seq(1, 0) !== 8'h3C) begin
      n_bad++;
      $display("FAIL msb_lane_seq got=%h/%h exp=a5/3c", lane_seq(0, 0), lane_seq(1, 0));
    end
    wd = rand_word();
    wd[7:0] = 8'h01;
    w_q = '{wd}; m_q = '{1'b1};
    run_queued("msb_01");
    n_total++;
    if (lane_seq(0, 0) !== 8'h80) begin
      n_bad++;
      $display("FAIL msb_01_seq got=%h exp=80", lane_seq(0, 0));
    end
  endtask

  task automatic test_back_to_back();
    w_q.delete(); m_q.delete();
    for (int k = 0; k < 4; k++) begin w_q.push_back(rand_word()); m_q.push_back(1'b0); end
    run_queued("back_to_back");
  endtask

  task automatic test_mode_switch();
    w_q = '{rand_word(), rand_word()};
    m_q = '{1'b0, 1'b1};
    run_queued("mode_switch");
  endtask

  task automatic test_random_stream();
    w_q.delete(); m_q.delete();
    for (int k = 0; k < 5; k++) begin
      w_q.push_back(rand_word());
      m_q.push_back(1'($urandom_range(0, 1)));
    end
    run_queued("random_stream");
  endtask

  task automatic test_abort();
    int acc_a, acc_b;
    logic [W-1:0] wa, wb;
    clear_capture();
    wa = rand_word();
    wb = rand_word();
    accept_word(wa, 1'b0, acc_a);
    accept_word(wb, 1'b1, acc_b);
    i_data_valid = 1'b0;
    repeat (acc_a + 5 - cyc) @(posedge i_clk);
    #1;
    i_ser_en = 1'b0;
    @(posedge i_clk); #1;
    n_total++;
    if ({o_data_ready, o_ser_data, o_valid_lane, o_clk_en, o_word_done} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs got=%b exp=0", {o_data_ready, o_ser_data, o_valid_lane, o_clk_en, o_word_done});
    end
    repeat (3) @(posedge i_clk);
    #1;
    i_ser_en = 1'b1;
    @(negedge i_clk);
    n_total++;
    if (o_data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_hold_discarded ready got=%b exp=1", o_data_ready);
    end
    repeat (4) @(posedge i_clk);
    #1;
    n_total++;
    if (q_data.size() != 5) begin
      n_bad++;
      $display("FAIL abort_ui_count got=%0d exp=5", q_data.size());
    end
    for (int t = 0; t < 5 && t < q_data.size(); t++) begin
      n_total++;
      if (q_data[t] !== exp_ui(wa, 1'b0, t)) begin
        n_bad++;
        $display("FAIL abort_partial_bits ui=%0d got=%b exp=%b", t, q_data[t], exp_ui(wa, 1'b0, t));
      end
    end
    w_q = '{rand_word()}; m_q = '{1'($urandom_range(0, 1))};
    run_queued("post_abort");
  endtask

  task automatic test_async_reset();
    int acc, sz0;
    clear_capture();
    accept_word(rand_word(), 1'b0, acc);
    i_data_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    sz0 = q_data.size();
    i_rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_data_ready, o_ser_data, o_valid_lane, o_clk_en, o_word_done} !== '0) begin
      n_bad++;
      $display("FAIL async_reset_outputs got=%b exp=0", {o_data_ready, o_ser_data, o_valid_lane, o_clk_en, o_word_done});
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    n_total++;
    if (o_data_ready !== 1'b1 || q_data.size() != sz0) begin
      n_bad++;
      $display("FAIL async_reset_recover ready=%b uis=%0d exp=1/%0d", o_data_ready, q_data.size(), sz0);
    end
    @(posedge i_clk); #1;
    w_q = '{rand_word()}; m_q = '{1'b1};
    run_queued("post_async_reset");
  endtask

  initial begin
    test_reset();
    test_single_lsb();
    test_msb();
    test_back_to_back();
    test_mode_switch();
    test_random_stream();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mb_tx_serializer_multi.md
Name: mb_tx_serializer_multi

Overview:
Parametrised multi-lane mainband TX serializer, the successor to the single-lane 32:1 serializer. It accepts one parallel word per lane through a valid/ready handshake and holds it in a one-deep holding buffer, so back-to-back words stream with zero idle UI. Each word is shifted out LSB- or MSB-first on every lane in parallel, alongside a valid-lane strobe and a forwarded-clock enable. It sits between the MB TX datapath (digital side) and the lane drivers, clocked by the high-speed serial clock.

Parameters:
LANES, 16, number of data lanes serialized in parallel (>=1)
SER_RATIO, 32, bits per lane per word (UI per word, >=2)
CNT_W, $clog2(SER_RATIO), width of the bit counter (derived, not overridden)

Ports:
i_clk  in  1  serial (UI-rate) clock
i_rst_n  in  1  asynchronous active-low reset
i_ser_en  in  1  serializer enable; low = synchronous abort/flush
i_msb_first  in  1  bit order for the word being loaded (0 = LSB first)
i_data  in  LANES*SER_RATIO  parallel word; lane l = i_data[l*SER_RATIO +: SER_RATIO]
i_data_valid  in  1  i_data valid
o_data_ready  out  1  holding buffer can accept a word
o_ser_data  out  LANES  serial bit per lane (flop output)
o_valid_lane  out  1  high for every UI carrying data
o_clk_en  out  1  forwarded-clock gate enable, equal to o_valid_lane
o_word_done  out  1  one-cycle pulse on the last UI of each word

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, hold_valid=0, shift regs=0, cnt=0. Outputs: o_data_ready=0, o_ser_data=0, o_valid_lane=0, o_clk_en=0, o_word_done=0.
- o_data_ready = i_ser_en & ~hold_valid. Accept when i_data_valid & o_data_ready. On accept: hold<=i_data, hold_mode<=i_msb_first, hold_valid<=1.
- FSM has two states: IDLE and SHIFT.
- load = hold_valid & (state==IDLE | (state==SHIFT & cnt==SER_RATIO-1)).
- On load: shift<=hold, mode<=hold_mode, cnt<=0, state<=SHIFT, hold_valid<=0.
  - Loading the first bit: for LSB-first, o_ser_data[l]<=hold[l][0] and the remaining bits shift right. For MSB-first, it takes bit SER_RATIO-1 and the rest shift left.
- SHIFT, cnt<SER_RATIO-1: cnt<=cnt+1; each lane presents its next bit.
- SHIFT, cnt==SER_RATIO-1, no load: state<=IDLE, o_ser_data<=0, cnt<=0.
- o_valid_lane = o_clk_en = (state==SHIFT). o_word_done = (state==SHIFT & cnt==SER_RATIO-1).
- Latency: accept at edge k, first UI visible after edge k+1 (IDLE start). Each word occupies exactly SER_RATIO UI.
- Continuous stream: if the source presents a new word within SER_RATIO-1 cycles of a load, the next load coincides with the last UI. No gap; o_valid_lane stays high.
- Mode is latched per word. A change of i_msb_first never affects a word already held or shifting.
- i_ser_en=0 (synchronous, any state) takes priority over accept and load: hold_valid<=0, shift<=0, state<=IDLE, cnt<=0, all outputs 0 next cycle. The in-flight word is discarded, not completed.
- Async reset mid-word: immediate clear, no partial completion.
- Lane mapping is fixed; all lanes share cnt, mode and state.

Decomposition:
- The shared package mb_tx_pkg holds the state typedef (IDLE, SHIFT) and the default LANES/SER_RATIO constants reused by the deserializer.
- One sub-module is natural: mb_ser_lane, a per-lane shift register with mode-controlled direction and load, instantiated LANES times by generate. The FSM, counter and handshake stay in the top.

Test Plan:
- Reset and enable: hold i_rst_n=0 for 3 cycles, then release with i_ser_en=1 -> all outputs 0, o_data_ready=1 the cycle after release.
- Single word (LANES=2, SER_RATIO=8, LSB first): lane0=0xA5, lane1=0x3C -> lane0 serial 1,0,1,0,0,1,0,1 and lane1 0,0,1,1,1,1,0,0. o_valid_lane high exactly 8 UI starting 1 cycle after accept; o_word_done on UI 8.
- MSB first, same data: lane0 sends 1,0,1,0,0,1,0,1 (0xA5 is a palindrome) and lane1 sends 0,0,1,1,1,1,0,0; repeat with 0x01 -> lane0 sends 0,0,0,0,0,0,0,1.
- Back-to-back: 4 random words (default 16x32) with valid held high -> 128 contiguous UI with no gap in o_valid_lane. o_data_ready pulses once per word; the loopback through the deserializer reproduces all 4 words.
- Mode switch between words: word0 LSB, word1 MSB -> each word follows the order latched at its accept, unaffected by later changes of i_msb_first.
- Abort: drop i_ser_en at UI 5 of a word with a second word held -> next cycle all outputs 0, hold discarded. After re-enable, a new word serializes normally with no residual bits.
